// File: rtl/hopfield_pkg.sv
// hopfield_pkg: shared sizes, types, FSM states and reference 5x5 letter patterns.
// Pattern bit r*5+c is row r, column c; each row literal below reads column 4..0.
package hopfield_pkg;
    localparam int N = 25;
    localparam int WW = 4;
    localparam int ADDR_W = 10;
    typedef logic signed [WW-1:0] weight_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [N-1:0] PAT_D = {5'b01111, 5'b10001, 5'b10001, 5'b10001, 5'b01111};
    localparam logic [N-1:0] PAT_C = {5'b11110, 5'b00001, 5'b00001, 5'b00001, 5'b11110};
    localparam logic [N-1:0] PAT_J = {5'b00110, 5'b01001, 5'b01000, 5'b01000, 5'b11111};
    localparam logic [N-1:0] PAT_M = {5'b10001, 5'b10001, 5'b10101, 5'b11011, 5'b10001};
endpackage

// File: rtl/hebb_term_sum.sv
// hebb_term_sum: signed Hebbian sum over enabled slots of +1 (bits agree) / -1 (bits differ).
module hebb_term_sum #(
    parameter int NPAT = 5,
    parameter int WW = 4
) (
    input  logic [NPAT-1:0] bk,
    input  logic [NPAT-1:0] bm,
    input  logic [NPAT-1:0] en,
    output logic signed [WW-1:0] w
);
    always_comb begin
        w = '0;
        for (int p = 0; p < NPAT; p++)
            if (en[p]) w = (bk[p] == bm[p]) ? w + WW'(1) : w - WW'(1);
    end
endmodule

// File: rtl/hebb_trainer.sv
// hebb_trainer: latches training patterns on start and streams the N x N Hebbian
// weight matrix into the recall-stage RAM, one row-major entry per clock.
module hebb_trainer #(
    parameter int N = 25,
    parameter int NPAT = 5,
    parameter int WW = 4,
    parameter int ZERO_DIAG = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NPAT*N-1:0]             pats,
    input  logic [NPAT-1:0]               pat_en,
    output logic                          busy,
    output logic                          done,
    output logic                          w_we,
    output logic [hopfield_pkg::ADDR_W-1:0] w_addr,
    output logic [WW-1:0]                 w_data
);
    import hopfield_pkg::*;

    localparam int KW = $clog2(N);
    localparam int LAST = N * N - 1;

    if (NPAT > 2 ** (WW - 1) - 1) begin : g_range_chk
        $error("hebb_trainer: NPAT does not fit the signed weight width");
    end

    state_t state, nxt;
    logic [KW-1:0] k, m;
    logic [ADDR_W-1:0] addr;
    logic [NPAT*N-1:0] pats_q;
    logic [NPAT-1:0] en_q, bk, bm;
    logic signed [WW-1:0] term;
    logic last, m_wrap;

    always_comb begin
        bk = '0;
        bm = '0;
        for (int p = 0; p < NPAT; p++) begin
            bk[p] = pats_q[p*N + int'(k)];
            bm[p] = pats_q[p*N + int'(m)];
        end
    end

    hebb_term_sum #(.NPAT(NPAT), .WW(WW)) u_sum (
        .bk(bk),
        .bm(bm),
        .en(en_q),
        .w (term)
    );

    assign last = addr == ADDR_W'(LAST);
    assign m_wrap = m == KW'(N - 1);

    always_comb begin
        nxt = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    assign busy = state == RUN;
    assign w_we = busy;
    assign done = state == DONE;
    assign w_addr = addr;
    // Data is forced to zero outside RUN so idle/reset outputs stay clean.
    assign w_data = (!busy || (ZERO_DIAG != 0 && k == m)) ? '0 : term;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            k <= '0;
            m <= '0;
            addr <= '0;
            pats_q <= '0;
            en_q <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                pats_q <= pats;
                en_q <= pat_en;
                k <= '0;
                m <= '0;
                addr <= '0;
            end else if (busy) begin
                m <= m_wrap ? '0 : m + 1'b1;
                k <= last ? '0 : m_wrap ? k + 1'b1 : k;
                addr <= last ? '0 : addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hebb_trainer.sv
// tb_hebb_trainer: directed table of pattern sets checked entry-by-entry against a Hebb
// model, plus mid-run reset, mid-run input disturbance and held-start sequences.
module tb_hebb_trainer;
    import hopfield_pkg::*;

    logic clk = 0, rst = 0, start = 0;
    logic [124:0] pats = '0;
    logic [4:0] pat_en = '0;
    logic busy, done, w_we, busyz, donez, w_wez;
    logic [9:0] w_addr, w_addrz;
    logic [3:0] w_data, w_dataz;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    hebb_trainer #(.N(25), .NPAT(5), .WW(4), .ZERO_DIAG(0)) dut (
        .clk(clk), .rst(rst), .start(start), .pats(pats), .pat_en(pat_en),
        .busy(busy), .done(done), .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
    );

    hebb_trainer #(.N(25), .NPAT(5), .WW(4), .ZERO_DIAG(1)) dutz (
        .clk(clk), .rst(rst), .start(start), .pats(pats), .pat_en(pat_en),
        .busy(busyz), .done(donez), .w_we(w_wez), .w_addr(w_addrz), .w_data(w_dataz)
    );

    typedef struct {
        logic [124:0] p;
        logic [4:0]   e;
        int           w01;
        int           diag;
    } vec_t;
    vec_t vt[4];

    function automatic int hebb(input logic [124:0] p, input logic [4:0] e, input int k, input int m);
        int agree = 0, n = 0;
        for (int q = 0; q < 5; q++) begin
            if (e[q]) begin
                n++;
                if (p[q*25 + k] == p[q*25 + m]) agree++;
            end
        end
        return 2 * agree - n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int sd(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    // Caller sits at a negedge with the trainer idle; stop_at < 625 aborts with reset.
    task automatic run(input vec_t v, input bit disturb, input int stop_at);
        int k, m, ex, exz;
        bit ok;
        start = 1;
        pats = v.p;
        pat_en = v.e;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 625; i++) begin
            k = i / 25;
            m = i % 25;
            ex = hebb(v.p, v.e, k, m);
            exz = (k == m) ? 0 : ex;
            ok = w_we && busy && !done && int'(w_addr) == i && sd(w_data) == ex &&
                 w_wez && !donez && int'(w_addrz) == i && sd(w_dataz) == exz;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL entry%0d: we=%b busy=%b done=%b addr=%0d data=%0d dataz=%0d want addr=%0d data=%0d dataz=%0d",
                         i, w_we, busy, done, w_addr, sd(w_data), sd(w_dataz), i, ex, exz);
            end
            if (i == 1) chk("w01", sd(w_data), v.w01);
            if (k == m) begin
                chk("diag", sd(w_data), v.diag);
                chk("diagz", sd(w_dataz), 0);
            end
            if (disturb && i == 100) begin
                start = 1;
                pats = ~v.p;
                pat_en = 5'b10101;
            end
            if (disturb && i == 101) start = 0;
            if (i == stop_at) begin
                rst = 0;
                @(negedge clk);
                chk("abort_outputs", {w_we, busy, done, w_wez, donez, w_addr, w_data}, 0);
                rst = 1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("abort_idle", {done, busy, w_we, donez}, 0);
                end
                return;
            end
            @(negedge clk);
        end
        chk("done_pulse", {done, busy, w_we}, 3'b100);
        chk("donez_pulse", {donez, busyz, w_wez}, 3'b100);
        @(negedge clk);
        chk("after_done", {done, busy, w_we}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, c;
        vt[0] = '{{100'b0, {25{1'b1}}}, 5'b00001, 1, 1};
        vt[1] = '{{25'b0, PAT_M, PAT_J, PAT_C, PAT_D}, 5'b11111, 1, 5};
        vt[2] = '{{25'b0, PAT_M, PAT_J, PAT_C, PAT_D}, 5'b00000, 0, 0};
        vt[3] = '{{100'b0, PAT_D}, 5'b00001, 1, 1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, w_we, w_addr, w_data}, 0);
        chk("resetz_outputs", {busyz, donez, w_wez, w_addrz, w_dataz}, 0);
        rst = 1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, w_we}, 0);

        for (int i = 0; i < 4; i++) run(vt[i], 0, 1000);

        run(vt[1], 0, 300);
        run(vt[1], 0, 1000);
        run(vt[3], 1, 1000);

        // Start held high: done pulses repeat every 627 cycles.
        d1 = -1;
        d2 = -1;
        start = 1;
        pats = vt[0].p;
        pat_en = vt[0].e;
        for (c = 1; c <= 1300; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        start = 0;
        chk("held_first_done", d1, 626);
        chk("held_period", d2 - d1, 627);
        c = 0;
        while (!done && c < 700) begin
            @(negedge clk);
            c++;
        end
        chk("held_drain_done", int'(done), 1);
        @(negedge clk);
        @(negedge clk);
        chk("held_drain_idle", {busy, done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
